composite_level_gen: RTL and testbench
======================================

COMPOSITE_LEVEL_GEN -- requirements
Module: composite_level_gen

Interface
REQ-001 The block SHALL have parameter PHASE_INC, default 32'd307480573, subcarrier NCO increment per clk (3.579545 MHz at 50 MHz clk).
REQ-002 The block SHALL have parameter PIX_DIV, default 10, clk cycles per active pixel.
REQ-003 The block SHALL have parameter NUM_PIX, default 256, pixels fetched per line.
REQ-004 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port state, input, 3, line-phase code from the line timer: 0 Hsync, 1 porch, 2 colourBurst, 3 activeVideo.
REQ-007 The block SHALL have port pix_ready, output, 1, one-cycle pixel request strobe.
REQ-008 The block SHALL have port pix_x, output, 8, index of the requested pixel, valid while pix_ready.
REQ-009 The block SHALL have port pix_valid, input, 1, pixel present on pix_data in the pix_ready cycle.
REQ-010 The block SHALL have port pix_data, input, 8, [7:4] luma, [3:1] hue, [0] chroma enable.
REQ-011 The block SHALL have port dac, output, 8, registered composite sample code.
REQ-012 The block SHALL have port underrun, output, 1, sticky flag: a requested pixel was missing.

Function
REQ-013 Levels SHALL be SYNC=0, BLANK=72, BLACK=84; active luma level = BLACK + 10*luma (84..234).
REQ-014 A 32-bit phase accumulator SHALL add PHASE_INC every clk, free-running in all states, wrapping mod 2^32.
REQ-015 Sine LUT SHALL have 32 entries, addressed by accumulator[31:27] plus offset mod 32, returning signed 8-bit round(20*sin(2*pi*addr/32)).
REQ-016 Hsync SHALL yield SYNC; porch SHALL yield BLANK; codes 4-7 SHALL yield BLANK.
REQ-017 colourBurst SHALL yield BLANK + LUT(offset 16), i.e. 180-degree burst, range 52..92.
REQ-018 activeVideo SHALL yield luma level of the current pixel, plus LUT(offset hue*4) when chroma enable=1.
REQ-019 Active pixel sequencing SHALL be a 3-state FSM: IDLE (state!=activeVideo), FETCH (active, pix count<NUM_PIX), DONE (active, all pixels fetched).
REQ-020 IDLE->FETCH SHALL occur on the first cycle state==activeVideo; pixel counter and divider SHALL clear on that entry.
REQ-021 In FETCH, pix_ready SHALL pulse for one cycle when divider==0; the divider SHALL count 0..PIX_DIV-1 and wrap.
REQ-022 On a pix_ready cycle with pix_valid=1, pix_data SHALL load the pixel register; with pix_valid=0, the pixel register SHALL load 8'h00 (black, no chroma) and underrun SHALL set.
REQ-023 After NUM_PIX requests the FSM SHALL enter DONE; DONE SHALL output BLACK with pix_ready low.
REQ-024 Any cycle with state!=activeVideo SHALL return the FSM to IDLE from FETCH or DONE, abandoning the line.
REQ-025 Output latency SHALL be exactly 2 clk from state/pix_data input to dac (stage 1 register, stage 2 level sum register).
REQ-026 The level sum SHALL be computed 9-bit signed and clamped to 0..255 before registering.

Reset
REQ-027 On reset, dac SHALL be BLANK (72), and pix_ready, underrun, accumulator, counters and pixel register SHALL be 0, FSM IDLE.
REQ-028 Reset asserted mid-line SHALL take priority over all state activity; after release the block SHALL resynchronise at the next activeVideo entry.

Structure
REQ-029 Level constants, state codes and FSM state encoding SHALL live in a shared package used with the line timer.
REQ-030 The sine table SHALL be a separate sub-module, subcarrier_lut, combinational 5-bit address to signed 8-bit data.

Verification
REQ-031 Reset held 5 cycles with state=3 -> dac=72, pix_ready=0, underrun=0 throughout.
REQ-032 state sequence 1,0,1 -> dac 72, then 0, then 72, each change exactly 2 clk after input change.
REQ-033 state=2 for 125 cycles -> dac within 52..92, period about 14 cycles, first sample 72+LUT(16+acc[31:27]).
REQ-034 state=3 for 2631 cycles, pix_valid=1, pix_data=8'hF0 -> 256 pix_ready pulses 10 clk apart, pix_x 0..255, dac=234 then 84 after pixel 255 period.
REQ-035 state=3, pix_valid=0 on request 5 -> pixel 5 outputs 84, underrun=1 and stays 1 until reset.
REQ-036 state drops 3->1 at pixel 100 -> pix_ready stops, dac=72 after 2 clk; next activeVideo entry restarts at pix_x=0.

Source files
------------

// File: rtl/composite_level_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : composite_level_gen_pkg
//  Purpose  : Shared composite-video level codes, line-phase codes and the
//             active-pixel FSM encoding, used by the level generator and
//             the line timer.
//  Revision : 1.0  initial release
// ============================================================================
package composite_level_gen_pkg;

  // DAC codes for the fixed composite levels
  localparam logic [7:0] LVL_SYNC  = 8'd0;
  localparam logic [7:0] LVL_BLANK = 8'd72;
  localparam logic [7:0] LVL_BLACK = 8'd84;
  localparam logic [7:0] LUMA_STEP = 8'd10;

  // Line-phase codes driven by the line timer (4..7 are unused)
  localparam logic [2:0] ST_HSYNC  = 3'd0;
  localparam logic [2:0] ST_PORCH  = 3'd1;
  localparam logic [2:0] ST_BURST  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;

  // Active-pixel sequencer encoding
  localparam logic [1:0] FSM_IDLE  = 2'd0;
  localparam logic [1:0] FSM_FETCH = 2'd1;
  localparam logic [1:0] FSM_DONE  = 2'd2;

  // Burst is sent 180 degrees from the reference phase (half the table)
  localparam logic [4:0] BURST_OFFSET = 5'd16;

  // Luma nibble to DAC code: black plus ten codes per step (84..234)
  function automatic logic [7:0] luma_level(input logic [3:0] luma);
    return LVL_BLACK + 8'(luma) * LUMA_STEP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/subcarrier_lut.sv
`default_nettype none
// ============================================================================
//  Module   : subcarrier_lut
//  Purpose  : 32-entry signed sine table, round(20*sin(2*pi*addr/32)).
//             Purely combinational.
//  Revision : 1.0  initial release
// ============================================================================
module subcarrier_lut (
  input  logic [4:0]        addr,
  output logic signed [7:0] data
);

  // Table lookup; second half is the negated first half
  always_comb begin
    data = 8'sd0;
    case (addr)
      5'd0:  data = 8'sd0;
      5'd1:  data = 8'sd4;
      5'd2:  data = 8'sd8;
      5'd3:  data = 8'sd11;
      5'd4:  data = 8'sd14;
      5'd5:  data = 8'sd17;
      5'd6:  data = 8'sd18;
      5'd7:  data = 8'sd20;
      5'd8:  data = 8'sd20;
      5'd9:  data = 8'sd20;
      5'd10: data = 8'sd18;
      5'd11: data = 8'sd17;
      5'd12: data = 8'sd14;
      5'd13: data = 8'sd11;
      5'd14: data = 8'sd8;
      5'd15: data = 8'sd4;
      5'd16: data = 8'sd0;
      5'd17: data = -8'sd4;
      5'd18: data = -8'sd8;
      5'd19: data = -8'sd11;
      5'd20: data = -8'sd14;
      5'd21: data = -8'sd17;
      5'd22: data = -8'sd18;
      5'd23: data = -8'sd20;
      5'd24: data = -8'sd20;
      5'd25: data = -8'sd20;
      5'd26: data = -8'sd18;
      5'd27: data = -8'sd17;
      5'd28: data = -8'sd14;
      5'd29: data = -8'sd11;
      5'd30: data = -8'sd8;
      5'd31: data = -8'sd4;
      default: data = 8'sd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/composite_level_gen.sv
`default_nettype none
// ============================================================================
//  Module   : composite_level_gen
//  Purpose  : Composite video level generator. Maps the line phase to sync,
//             blank, burst or active-video levels, fetches NUM_PIX pixels per
//             line at one pixel per PIX_DIV clocks and adds a chroma
//             subcarrier from a free-running NCO. Two-stage output pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module composite_level_gen
  import composite_level_gen_pkg::*;
#(
  parameter logic [31:0] PHASE_INC = 32'd307480573,
  parameter int          PIX_DIV   = 10,
  parameter int          NUM_PIX   = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state,
  output logic       pix_ready,
  output logic [7:0] pix_x,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic [7:0] dac,
  output logic       underrun
);

  localparam int DIV_W = $clog2(PIX_DIV + 1);
  localparam int CNT_W = 9;  // must reach NUM_PIX (up to 256)
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(NUM_PIX);

  logic [31:0]       r_acc;
  logic [1:0]        r_fsm;
  logic [CNT_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [7:0]        r_pix;
  logic              r_underrun;
  logic [7:0]        r_base;
  logic signed [7:0] r_chroma;
  logic [7:0]        r_dac;

  logic              w_pix_ready;
  logic [7:0]        w_cur_pix;
  logic [4:0]        w_lut_addr;
  logic signed [7:0] w_lut_data;
  logic [7:0]        w_base;
  logic signed [7:0] w_chroma;
  logic signed [8:0] w_sum;
  logic [7:0]        w_dac;

  // Request only while actively fetching; gated by the live phase so a line
  // that is abandoned this cycle does not issue a stray request.
  assign w_pix_ready = (state == ST_ACTIVE) && (r_fsm == FSM_FETCH) &&
                       (r_div == '0) && (r_cnt < CNT_END);

  // On a request cycle the fresh pixel is used directly so pix_data reaches
  // the DAC with the same two-clock latency as the phase code.
  assign w_cur_pix  = w_pix_ready ? (pix_valid ? pix_data : 8'h00) : r_pix;
  assign w_lut_addr = r_acc[31:27] +
                      ((state == ST_BURST) ? BURST_OFFSET : {w_cur_pix[3:1], 2'b00});

  assign pix_ready = w_pix_ready;
  assign pix_x     = r_cnt[7:0];
  assign underrun  = r_underrun;
  assign dac       = r_dac;

  subcarrier_lut u_lut (
    .addr (w_lut_addr),
    .data (w_lut_data)
  );

  // Free-running subcarrier phase accumulator
  always_ff @(posedge clk) begin
    if (reset) r_acc <= '0;
    else       r_acc <= r_acc + PHASE_INC;
  end

  // Pixel sequencer: entry, per-pixel divider, fetch and underrun capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm      <= FSM_IDLE;
      r_cnt      <= '0;
      r_div      <= '0;
      r_pix      <= 8'h00;
      r_underrun <= 1'b0;
    end else if (state != ST_ACTIVE) begin
      r_fsm <= FSM_IDLE;
    end else begin
      case (r_fsm)
        FSM_IDLE: begin
          r_fsm <= FSM_FETCH;
          r_cnt <= '0;
          r_div <= '0;
        end
        FSM_FETCH: begin
          if (w_pix_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_pix <= w_cur_pix;
            if (!pix_valid) r_underrun <= 1'b1;
          end
          r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
          // Leave only once the last pixel has had its full display period
          if ((r_div == DIV_LAST) && (r_cnt == CNT_END)) r_fsm <= FSM_DONE;
        end
        FSM_DONE:  r_fsm <= FSM_DONE;
        default:   r_fsm <= FSM_IDLE;
      endcase
    end
  end

  // Stage-1 level selection: base level and signed subcarrier term
  always_comb begin
    w_base   = LVL_BLANK;
    w_chroma = 8'sd0;
    case (state)
      ST_HSYNC: w_base = LVL_SYNC;
      ST_PORCH: w_base = LVL_BLANK;
      ST_BURST: w_chroma = w_lut_data;
      ST_ACTIVE: begin
        if (r_fsm == FSM_FETCH) begin
          w_base = luma_level(w_cur_pix[7:4]);
          if (w_cur_pix[0]) w_chroma = w_lut_data;
        end else begin
          w_base = LVL_BLACK;
        end
      end
      default: w_base = LVL_BLANK;
    endcase
  end

  // Stage-1 pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base   <= LVL_BLANK;
      r_chroma <= 8'sd0;
    end else begin
      r_base   <= w_base;
      r_chroma <= w_chroma;
    end
  end

  // Level sum in 9-bit signed, negatives clamped to zero
  assign w_sum = $signed({1'b0, r_base}) + $signed({r_chroma[7], r_chroma});
  assign w_dac = w_sum[8] ? 8'd0 : w_sum[7:0];

  // Stage-2 output register
  always_ff @(posedge clk) begin
    if (reset) r_dac <= LVL_BLANK;
    else       r_dac <= w_dac;
  end

endmodule
`default_nettype wire

// File: tb/tb_composite_level_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_composite_level_gen
//  Purpose  : Self-checking bench for composite_level_gen against a
//             behavioural line model (cycle position within the line,
//             floating-point sine reference, two-deep output delay).
//  Revision : 1.0  initial release
// ============================================================================
module tb_composite_level_gen;

  localparam logic [31:0] INC     = 32'd307480573;
  localparam int          PIX_DIV = 10;
  localparam int          NUM_PIX = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] state = 3'd3;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       pix_ready;
  logic [7:0] pix_x;
  logic [7:0] dac;
  logic       underrun;

  composite_level_gen #(
    .PHASE_INC (INC),
    .PIX_DIV   (PIX_DIV),
    .NUM_PIX   (NUM_PIX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .dac       (dac),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int ready_count = 0;

  // Reference model state
  logic [31:0] m_acc = 32'd0;
  int          m_pipe1 = 72;
  int          m_dac = 72;
  int          m_n = 0;
  bit          m_prev_active = 1'b0;
  logic [7:0]  m_pix = 8'h00;
  bit          m_underrun = 1'b0;

  function automatic int lut_ref(input int a);
    real v;
    v = 20.0 * $sin(2.0 * 3.14159265358979 * real'(a % 32) / 32.0);
    if (v >= 0.0) return int'($floor(v + 0.5));
    else          return -int'($floor(-v + 0.5));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: inputs are already driven; check the request
  // strobe before the edge and the output/underrun after it.
  task automatic cycle();
    int n, x, s, a5;
    bit act, req;
    logic [7:0] pix_now;
    act = !reset && (state == 3'd3);
    n   = (act && m_prev_active) ? m_n + 1 : 0;
    req = act && (n >= 1) && ((n - 1) % PIX_DIV == 0) && ((n - 1) / PIX_DIV < NUM_PIX);
    x   = (n >= 1) ? (n - 1) / PIX_DIV : 0;
    pix_now = req ? (pix_valid ? pix_data : 8'h00) : m_pix;
    a5  = int'(m_acc[31:27]);
    case (state)
      3'd0: s = 0;
      3'd1: s = 72;
      3'd2: s = 72 + lut_ref(a5 + 16);
      3'd3: begin
        if (n >= 1 && n <= NUM_PIX * PIX_DIV)
          s = 84 + 10 * int'(pix_now[7:4]) +
              (pix_now[0] ? lut_ref(a5 + 4 * int'(pix_now[3:1])) : 0);
        else
          s = 84;
      end
      default: s = 72;
    endcase
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    #2;
    check("pix_ready", 32'(pix_ready), 32'(req));
    if (req) check("pix_x", 32'(pix_x), 32'(x));
    if (pix_ready) ready_count++;
    @(posedge clk);
    if (reset) begin
      m_acc = 32'd0; m_pipe1 = 72; m_dac = 72; m_pix = 8'h00;
      m_underrun = 1'b0; m_prev_active = 1'b0; m_n = 0;
    end else begin
      m_dac   = m_pipe1;
      m_pipe1 = s;
      m_acc   = m_acc + INC;
      if (req) m_pix = pix_now;
      if (req && !pix_valid) m_underrun = 1'b1;
      m_prev_active = act;
      m_n = n;
    end
    #1;
    check("dac", 32'(dac), 32'(m_dac));
    check("underrun", 32'(underrun), 32'(m_underrun));
  endtask

  initial begin
    // Settle registers under reset before any checks
    repeat (2) @(posedge clk);
    #1;

    // Reset held with state=3: blank output, no requests, no underrun
    for (int i = 0; i < 5; i++) cycle();
    reset = 1'b0;

    // Porch / hsync / porch with two-clock output latency
    state = 3'd1; for (int i = 0; i < 3; i++) cycle();
    state = 3'd0; for (int i = 0; i < 3; i++) cycle();
    state = 3'd1; for (int i = 0; i < 3; i++) cycle();

    // Colour burst
    state = 3'd2; for (int i = 0; i < 125; i++) cycle();
    state = 3'd1; for (int i = 0; i < 3; i++) cycle();

    // Full line of white pixels
    ready_count = 0;
    state = 3'd3; pix_valid = 1'b1; pix_data = 8'hF0;
    for (int i = 0; i < 2631; i++) cycle();
    check("line_requests", 32'(ready_count), 32'd256);
    state = 3'd1; for (int i = 0; i < 3; i++) cycle();

    // Random pixels, missing pixel 5, line abandoned at pixel 100
    state = 3'd3;
    for (int i = 0; i < 1001; i++) begin
      pix_data  = 8'($urandom);
      pix_valid = (i != 51);
      cycle();
    end
    state = 3'd1; pix_valid = 1'b1;
    for (int i = 0; i < 5; i++) cycle();

    // Re-entry restarts at pixel 0
    state = 3'd3;
    for (int i = 0; i < 60; i++) begin
      pix_data = 8'($urandom);
      cycle();
    end

    // Random phase sequence including unused codes and short lines
    for (int seg = 0; seg < 60; seg++) begin
      state = 3'($urandom_range(0, 7));
      for (int i = 0, len = $urandom_range(1, 60); i < len; i++) begin
        pix_data  = 8'($urandom);
        pix_valid = ($urandom_range(0, 9) != 0);
        cycle();
      end
    end

    // Reset mid-line clears the sticky flag and resynchronises
    state = 3'd3; pix_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin pix_data = 8'($urandom); cycle(); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin pix_data = 8'($urandom); cycle(); end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
